memory_access_stage: RTL and testbench
======================================

// Module: memory_access_stage
// PURPOSE
//  MEM stage directly downstream of execute_stage; consumes its o_control_signal and o_rd_output (address or ALU result).
//  Loads/stores (control_s.mem=1) run a req/ack data-memory transaction with byte-lane steering and load sign/zero-extension.
//  Non-memory ops pass o_rd_output through unchanged. Result is handed to write-back with a done/ready handshake.
// PARAMETERS
//  XLEN            32  datapath / address width (from rapid_pkg)
//  TIMEOUT_CYCLES  16  max ACCESS cycles without i_mem_ack before bus-timeout fault (>=2)
// PORTS
//  i_clk             in   1     clock
//  i_reset           in   1     asynchronous, active-high reset
//  i_valid           in   1     execute o_done; inputs valid this cycle
//  i_control_signal  in   control_s  mem, iop (1=store), fcs_opcode[2:0]=width
//  i_rd_output       in   XLEN  effective address (mem) or result (non-mem)
//  i_rs2             in   XLEN  store data
//  i_wb_ready        in   1     write-back accepts result
//  i_mem_ack         in   1     memory completes access this cycle
//  i_mem_rdata       in   XLEN  read word, valid with i_mem_ack
//  o_mem_req         out  1     access request, held until ack/timeout
//  o_mem_we          out  1     1=store
//  o_mem_addr        out  XLEN  word-aligned address {addr[XLEN-1:2],2'b00}
//  o_mem_be          out  4     byte enables
//  o_mem_wdata       out  XLEN  lane-replicated store data
//  o_control_signal  out  control_s  latched control, to write-back
//  o_rd_data         out  XLEN  load data / pass-through result / 0 for stores
//  o_done            out  1     result valid, held until i_wb_ready
//  o_fault           out  1     access faulted (qualifies o_done)
//  o_fault_cause     out  2     00 none, 01 misaligned, 10 bus timeout, 11 illegal width
//  o_current_state   out  MEM_state_t  for verification
// BEHAVIOUR
//  Reset (async): state=MEM_IDLE; all outputs 0; o_control_signal=control_s_default(); timeout counter 0.
//  MEM_IDLE: i_valid=1 -> latch control/address/rs2; mem=0 -> MEM_DONE, o_rd_data=i_rd_output;
//   mem=1 and fault-check fails -> MEM_DONE with o_fault; else -> MEM_ACCESS. i_valid ignored outside IDLE.
//  Fault check: fcs_opcode 011/110/111, or stores with 100/101 -> illegal (11); LH/LHU/SH addr[0]=1 or
//   LW/SW addr[1:0]!=0 -> misaligned (01). Faulted accesses never assert o_mem_req.
//  MEM_ACCESS: o_mem_req=1, addr/be/wdata/we stable; counter++ each cycle. i_mem_ack=1 -> register
//   extracted load data, -> MEM_DONE. Counter==TIMEOUT_CYCLES-1 and no ack -> MEM_DONE, cause 10.
//   Ack and timeout in same cycle: ack wins, no fault.
//  MEM_DONE: o_done=1, outputs stable; i_wb_ready=1 -> MEM_IDLE next cycle (o_done low in IDLE).
//  Latency: non-mem/fault: i_valid edge -> o_done next cycle. Mem, ack in first ACCESS cycle: o_done 2 cycles after capture.
//  Byte lanes (a=addr[1:0]): SB be=4'b0001<<a, wdata={4{rs2[7:0]}}; SH be=4'b0011<<a, wdata={2{rs2[15:0]}};
//   SW be=4'b1111, wdata=rs2. Loads: be=4'b1111, we=0.
//  Load extract: sh=rdata>>(8*a); LB sext sh[7:0], LBU zext sh[7:0], LH sext sh[15:0], LHU zext sh[15:0], LW rdata.
//  Stores: o_rd_data=0. Faulted: o_rd_data=0.
//  Reset mid-ACCESS: o_mem_req drops immediately; late i_mem_ack in IDLE ignored.
//  Counter width $clog2(TIMEOUT_CYCLES); cleared on entry to MEM_ACCESS.
// STRUCTURE
//  rapid_pkg: add MEM_state_t {MEM_RESET, MEM_IDLE, MEM_ACCESS, MEM_DONE}, fault-cause enum,
//   width constants (LB_or_SB, LH_or_SH, LW_or_SW, LBU, LHU) moved here from file-local localparams.
//  Sub-module mem_lane_align (combinational): addr[1:0]+fcs_opcode+iop -> be, wdata, load extract, fault cause.
//  Top: FSM, input latches, timeout counter, output registers.
// TESTING
//  LW addr=0x100, rdata=0xDEADBEEF, ack in 1st ACCESS cycle -> be=1111, addr=0x100, o_rd_data=0xDEADBEEF, done 2 cycles after capture.
//  LB addr=0x103, rdata=0x80FF_0000 -> o_rd_data=0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x102 -> 0x000080FF.
//  SH addr=0x202, rs2=0x1234ABCD -> we=1, be=1100, wdata=0xABCDABCD, addr=0x200, o_rd_data=0.
//  LW addr=0x101 -> no o_mem_req, o_fault=1, cause=01, o_done next cycle; fcs_opcode=011 -> cause=11.
//  No ack for 16 cycles -> req held 16 cycles, then done with cause=10; ack on cycle 16 -> no fault.
//  Non-mem result 0x55, i_wb_ready=0 for 3 cycles -> o_done held, o_rd_data=0x55 stable; async reset mid-ACCESS -> req low immediately.

Source files
------------

// File: rtl/rapid_pkg.sv
// Shared pipeline types for the rapid core: control word, MEM stage states,
// fault causes and load/store width encodings.
package rapid_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic       reg_write;
    logic [4:0] rd_addr;
    logic       mem;
    logic       iop;
    logic [2:0] fcs_opcode;
  } control_s;

  typedef enum logic [1:0] {
    MEM_RESET  = 2'd0,
    MEM_IDLE   = 2'd1,
    MEM_ACCESS = 2'd2,
    MEM_DONE   = 2'd3
  } MEM_state_t;

  typedef enum logic [1:0] {
    FAULT_NONE          = 2'b00,
    FAULT_MISALIGNED    = 2'b01,
    FAULT_BUS_TIMEOUT   = 2'b10,
    FAULT_ILLEGAL_WIDTH = 2'b11
  } fault_cause_t;

  localparam logic [2:0] LB_or_SB = 3'b000;
  localparam logic [2:0] LH_or_SH = 3'b001;
  localparam logic [2:0] LW_or_SW = 3'b010;
  localparam logic [2:0] LBU      = 3'b100;
  localparam logic [2:0] LHU      = 3'b101;

  function automatic control_s control_s_default();
    control_s c;
    c = '0;
    return c;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store enables/replicated data, load
// extraction with sign/zero extension, and width/alignment fault detection.
module mem_lane_align
  import rapid_pkg::*;
(
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      width,
  input  logic            is_store,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] load_word,
  output logic [3:0]      byte_en,
  output logic [XLEN-1:0] write_data,
  output logic [XLEN-1:0] load_data,
  output fault_cause_t    fault_cause
);

  logic [XLEN-1:0] shifted_s;

  assign shifted_s = load_word >> {addr_lo, 3'b000};

  // Store lane enables and data replication; loads always read the full word.
  always_comb begin
    byte_en    = 4'b0000;
    write_data = '0;
    if (is_store) begin
      case (width)
        LB_or_SB: begin
          byte_en    = 4'b0001 << addr_lo;
          write_data = {4{store_data[7:0]}};
        end
        LH_or_SH: begin
          byte_en    = 4'b0011 << addr_lo;
          write_data = {2{store_data[15:0]}};
        end
        LW_or_SW: begin
          byte_en    = 4'b1111;
          write_data = store_data;
        end
        default: begin
          byte_en    = 4'b0000;
          write_data = '0;
        end
      endcase
    end else begin
      byte_en    = 4'b1111;
      write_data = '0;
    end
  end

  // Load extraction from the lane-shifted word.
  always_comb begin
    load_data = '0;
    case (width)
      LB_or_SB: load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
      LBU:      load_data = {24'd0, shifted_s[7:0]};
      LH_or_SH: load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
      LHU:      load_data = {16'd0, shifted_s[15:0]};
      LW_or_SW: load_data = load_word;
      default:  load_data = '0;
    endcase
  end

  // Illegal widths take priority over misalignment.
  always_comb begin
    fault_cause = FAULT_NONE;
    case (width)
      LB_or_SB: fault_cause = FAULT_NONE;
      LH_or_SH: fault_cause = addr_lo[0] ? FAULT_MISALIGNED : FAULT_NONE;
      LW_or_SW: fault_cause = (addr_lo != 2'b00) ? FAULT_MISALIGNED : FAULT_NONE;
      LBU:      fault_cause = is_store ? FAULT_ILLEGAL_WIDTH : FAULT_NONE;
      LHU:      fault_cause = is_store ? FAULT_ILLEGAL_WIDTH :
                              (addr_lo[0] ? FAULT_MISALIGNED : FAULT_NONE);
      default:  fault_cause = FAULT_ILLEGAL_WIDTH;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: latches execute results, runs a req/ack data-memory
// access for loads/stores with a bus timeout, and hands the result to write-back.
module memory_access_stage
  import rapid_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_valid,
  input  control_s        i_control_signal,
  input  logic [XLEN-1:0] i_rd_output,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_wb_ready,
  input  logic            i_mem_ack,
  input  logic [XLEN-1:0] i_mem_rdata,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [3:0]      o_mem_be,
  output logic [XLEN-1:0] o_mem_wdata,
  output control_s        o_control_signal,
  output logic [XLEN-1:0] o_rd_data,
  output logic            o_done,
  output logic            o_fault,
  output logic [1:0]      o_fault_cause,
  output MEM_state_t      o_current_state
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  MEM_state_t       state_r;
  MEM_state_t       next_state_s;
  control_s         ctrl_r;
  logic [XLEN-1:0]  addr_r;
  logic [XLEN-1:0]  rs2_r;
  logic [XLEN-1:0]  rd_data_r;
  logic             fault_r;
  fault_cause_t     cause_r;
  logic [CNT_W-1:0] cnt_r;

  logic             idle_s;
  logic             access_s;
  logic             capture_s;
  logic             timeout_s;
  logic [1:0]       lane_addr_s;
  logic [2:0]       lane_width_s;
  logic             lane_store_s;
  logic [3:0]       lane_be_s;
  logic [XLEN-1:0]  lane_wdata_s;
  logic [XLEN-1:0]  lane_load_s;
  fault_cause_t     lane_fault_s;

  assign idle_s    = (state_r == MEM_IDLE);
  assign access_s  = (state_r == MEM_ACCESS);
  assign capture_s = idle_s && i_valid;
  assign timeout_s = access_s && !i_mem_ack && (cnt_r == CNT_LAST);

  // In IDLE the aligner checks the incoming op; afterwards it works on the latched one.
  assign lane_addr_s  = idle_s ? i_rd_output[1:0]            : addr_r[1:0];
  assign lane_width_s = idle_s ? i_control_signal.fcs_opcode : ctrl_r.fcs_opcode;
  assign lane_store_s = idle_s ? i_control_signal.iop        : ctrl_r.iop;

  mem_lane_align u_lane_align (
    .addr_lo     (lane_addr_s),
    .width       (lane_width_s),
    .is_store    (lane_store_s),
    .store_data  (rs2_r),
    .load_word   (i_mem_rdata),
    .byte_en     (lane_be_s),
    .write_data  (lane_wdata_s),
    .load_data   (lane_load_s),
    .fault_cause (lane_fault_s)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r <= MEM_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; an ack in the final timeout cycle still completes cleanly.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      MEM_IDLE: begin
        if (!i_valid) begin
          next_state_s = MEM_IDLE;
        end else if (i_control_signal.mem && (lane_fault_s == FAULT_NONE)) begin
          next_state_s = MEM_ACCESS;
        end else begin
          next_state_s = MEM_DONE;
        end
      end
      MEM_ACCESS: begin
        if (i_mem_ack || timeout_s) begin
          next_state_s = MEM_DONE;
        end else begin
          next_state_s = MEM_ACCESS;
        end
      end
      MEM_DONE: begin
        if (i_wb_ready) begin
          next_state_s = MEM_IDLE;
        end else begin
          next_state_s = MEM_DONE;
        end
      end
      default: next_state_s = MEM_IDLE;
    endcase
  end

  // Input latches, timeout counter and result registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ctrl_r    <= control_s_default();
      addr_r    <= '0;
      rs2_r     <= '0;
      rd_data_r <= '0;
      fault_r   <= 1'b0;
      cause_r   <= FAULT_NONE;
      cnt_r     <= '0;
    end else if (capture_s) begin
      ctrl_r <= i_control_signal;
      addr_r <= i_rd_output;
      rs2_r  <= i_rs2;
      cnt_r  <= '0;
      if (i_control_signal.mem) begin
        rd_data_r <= '0;
        fault_r   <= (lane_fault_s != FAULT_NONE);
        cause_r   <= lane_fault_s;
      end else begin
        rd_data_r <= i_rd_output;
        fault_r   <= 1'b0;
        cause_r   <= FAULT_NONE;
      end
    end else if (access_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
      if (i_mem_ack) begin
        rd_data_r <= ctrl_r.iop ? '0 : lane_load_s;
        fault_r   <= 1'b0;
        cause_r   <= FAULT_NONE;
      end else if (timeout_s) begin
        rd_data_r <= '0;
        fault_r   <= 1'b1;
        cause_r   <= FAULT_BUS_TIMEOUT;
      end else begin
        rd_data_r <= rd_data_r;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Bus outputs decode from the state register and latched operands only.
  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_be    = 4'b0000;
    o_mem_wdata = '0;
    if (access_s) begin
      o_mem_req   = 1'b1;
      o_mem_we    = ctrl_r.iop;
      o_mem_addr  = {addr_r[XLEN-1:2], 2'b00};
      o_mem_be    = lane_be_s;
      o_mem_wdata = lane_wdata_s;
    end else begin
      o_mem_req = 1'b0;
    end
  end

  assign o_done           = (state_r == MEM_DONE);
  assign o_control_signal = ctrl_r;
  assign o_rd_data        = rd_data_r;
  assign o_fault          = fault_r;
  assign o_fault_cause    = cause_r;
  assign o_current_state  = state_r;

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage: a driver issues directed and random
// ops and plays the memory; a monitor checks each result at the write-back handshake.
module tb_memory_access_stage;
  import rapid_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_valid;
  control_s    i_control_signal;
  logic [31:0] i_rd_output;
  logic [31:0] i_rs2;
  logic        i_wb_ready;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_wdata;
  control_s    o_control_signal;
  logic [31:0] o_rd_data;
  logic        o_done;
  logic        o_fault;
  logic [1:0]  o_fault_cause;
  MEM_state_t  o_current_state;

  always #5 clk = ~clk;

  memory_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk            (clk),
    .i_reset          (i_reset),
    .i_valid          (i_valid),
    .i_control_signal (i_control_signal),
    .i_rd_output      (i_rd_output),
    .i_rs2            (i_rs2),
    .i_wb_ready       (i_wb_ready),
    .i_mem_ack        (i_mem_ack),
    .i_mem_rdata      (i_mem_rdata),
    .o_mem_req        (o_mem_req),
    .o_mem_we         (o_mem_we),
    .o_mem_addr       (o_mem_addr),
    .o_mem_be         (o_mem_be),
    .o_mem_wdata      (o_mem_wdata),
    .o_control_signal (o_control_signal),
    .o_rd_data        (o_rd_data),
    .o_done           (o_done),
    .o_fault          (o_fault),
    .o_fault_cause    (o_fault_cause),
    .o_current_state  (o_current_state)
  );

  typedef struct {
    logic [31:0] rd;
    logic        fault;
    logic [1:0]  cause;
    control_s    ctrl;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Reference model: result, bus lanes, request count and done latency of one op.
  function automatic exp_t model(input control_s c, input logic [31:0] addr, input logic [31:0] rs2,
                                 input logic [31:0] rdata, input int ack_delay,
                                 output int lat, output int reqs,
                                 output logic [3:0] be, output logic [31:0] wd);
    exp_t        e;
    int          w, size, off, bits;
    bit          illegal, mis;
    logic [63:0] v;
    w       = int'(c.fcs_opcode);
    size    = 1 << (w % 4);
    off     = int'(addr % 4);
    illegal = (w == 3 || w == 6 || w == 7) || (c.iop && (w == 4 || w == 5));
    mis     = (addr % size) != 0;
    e.ctrl = c; e.fault = 1'b0; e.cause = 2'd0; e.rd = 32'd0;
    lat = 1; reqs = 0; be = 4'd0; wd = 32'd0;
    if (!c.mem) begin
      e.rd = addr;
    end else if (illegal) begin
      e.fault = 1'b1; e.cause = 2'd3;
    end else if (mis) begin
      e.fault = 1'b1; e.cause = 2'd1;
    end else begin
      reqs = (ack_delay < TO) ? ack_delay + 1 : TO;
      lat  = 1 + reqs;
      be   = c.iop ? 4'(((1 << size) - 1) << off) : 4'hF;
      wd   = (size == 1) ? (rs2 % 256) * 32'h01010101 :
             (size == 2) ? (rs2 % 65536) * 32'h00010001 : rs2;
      if (ack_delay >= TO) begin
        e.fault = 1'b1; e.cause = 2'd2;
      end else if (!c.iop) begin
        bits = 8 * size;
        v = {32'd0, rdata} >> (8 * off);
        v = v & ((64'd1 << bits) - 64'd1);
        if (w < 2 && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
        e.rd = v[31:0];
      end
    end
    return e;
  endfunction

  function automatic control_s mk_ctrl(input bit mem, input bit iop, input int w);
    control_s c;
    c            = control_s_default();
    c.reg_write  = 1'($urandom_range(0, 1));
    c.rd_addr    = 5'($urandom_range(0, 31));
    c.mem        = mem;
    c.iop        = iop;
    c.fcs_opcode = 3'(w);
    return c;
  endfunction

  // Monitor: compare at each write-back handshake, and check held results while stalled.
  always @(negedge clk) begin
    if (!i_reset && o_done) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else if (i_wb_ready) begin
        mon_e = sb_q.pop_front();
        check("rd_data", o_rd_data, mon_e.rd);
        check("fault", 32'(o_fault), 32'(mon_e.fault));
        check("fault_cause", 32'(o_fault_cause), 32'(mon_e.cause));
        check("control", 32'(o_control_signal), 32'(mon_e.ctrl));
      end else begin
        check("held_rd_data", o_rd_data, sb_q[0].rd);
      end
    end
  end

  task automatic run_txn(input control_s c, input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [31:0] rdata, input int ack_delay, input int wb_delay);
    exp_t        e;
    int          lat, reqs, seen, n;
    logic [3:0]  be;
    logic [31:0] wd, r;
    bit          done;
    e = model(c, addr, rs2, rdata, ack_delay, lat, reqs, be, wd);
    sb_q.push_back(e);
    @(posedge clk); #2;
    i_valid = 1'b1; i_control_signal = c; i_rd_output = addr; i_rs2 = rs2;
    @(posedge clk); #2;
    r = $urandom;
    i_valid          = 1'($urandom_range(0, 1));
    i_control_signal = control_s'(r[$bits(control_s)-1:0]);
    i_rd_output      = $urandom;
    i_rs2            = $urandom;
    n = 0; seen = 0; done = 1'b0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (o_done) begin
        done = 1'b1;
      end else if (o_mem_req) begin
        if (seen == 0) begin
          check("mem_addr", o_mem_addr, addr & 32'hFFFF_FFFC);
          check("mem_we", 32'(o_mem_we), 32'(c.iop));
          check("mem_be", 32'(o_mem_be), 32'(be));
          if (c.iop) check("mem_wdata", o_mem_wdata, wd);
        end
        seen++;
        i_mem_ack   = (seen - 1 == ack_delay);
        i_mem_rdata = i_mem_ack ? rdata : $urandom;
      end else begin
        i_mem_ack = 1'b0;
      end
    end
    i_mem_ack = 1'b0;
    check("req_cycles", seen, reqs);
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=no_done required=done_within_40");
      void'(sb_q.pop_back());
      return;
    end
    check("latency", n, lat);
    for (int k = 0; k < wb_delay; k++) begin
      @(posedge clk); #2;
      i_wb_ready = 1'b0;
      @(negedge clk);
    end
    @(posedge clk); #2;
    i_wb_ready = 1'b1;
    i_valid    = 1'b0;
    @(negedge clk);
    @(posedge clk); #2;
    i_wb_ready = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1; i_valid = 1'b0; i_control_signal = control_s_default();
    i_rd_output = 32'd0; i_rs2 = 32'd0; i_wb_ready = 1'b0; i_mem_ack = 1'b0; i_mem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_state", 32'(o_current_state), 32'(MEM_IDLE));
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_req", 32'(o_mem_req), 32'd0);
    check("rst_rd_data", o_rd_data, 32'd0);
    check("rst_fault", 32'({o_fault, o_fault_cause}), 32'd0);
    check("rst_control", 32'(o_control_signal), 32'(control_s_default()));
    check("rst_be", 32'(o_mem_be), 32'd0);
    i_reset = 1'b0;

    run_txn(mk_ctrl(1, 0, 2), 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
    run_txn(mk_ctrl(1, 0, 0), 32'h103, 32'h0, 32'h80FF0000, 1, 1);
    run_txn(mk_ctrl(1, 0, 4), 32'h103, 32'h0, 32'h80FF0000, 0, 0);
    run_txn(mk_ctrl(1, 0, 5), 32'h102, 32'h0, 32'h80FF0000, 2, 0);
    run_txn(mk_ctrl(1, 1, 1), 32'h202, 32'h1234ABCD, 32'h0, 0, 0);
    run_txn(mk_ctrl(1, 0, 2), 32'h101, 32'h0, 32'h0, 0, 0);
    run_txn(mk_ctrl(1, 0, 3), 32'h100, 32'h0, 32'h0, 0, 0);
    run_txn(mk_ctrl(1, 1, 4), 32'h100, 32'h0, 32'h0, 0, 0);
    run_txn(mk_ctrl(1, 0, 2), 32'h400, 32'h0, 32'h0, 100, 1);
    run_txn(mk_ctrl(1, 0, 2), 32'h404, 32'h0, 32'hCAFEF00D, TO - 1, 0);
    run_txn(mk_ctrl(0, 0, 0), 32'h55, 32'h0, 32'h0, 0, 3);

    for (int t = 0; t < 80; t++) begin
      int ad;
      ad = ($urandom_range(0, 9) == 0) ? 30 : int'($urandom_range(0, 4));
      run_txn(mk_ctrl(($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 7))),
              $urandom, $urandom, $urandom, ad, int'($urandom_range(0, 3)));
    end

    // Asynchronous reset in the middle of an access, then a stray late ack.
    @(posedge clk); #2;
    i_valid = 1'b1; i_control_signal = mk_ctrl(1, 0, 2); i_rd_output = 32'h300;
    @(posedge clk); #2;
    i_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_req", 32'(o_mem_req), 32'd1);
    #3 i_reset = 1'b1;
    #1;
    check("reset_req_drop", 32'(o_mem_req), 32'd0);
    check("reset_state", 32'(o_current_state), 32'(MEM_IDLE));
    @(posedge clk); #2;
    i_reset = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'h12345678;
    @(negedge clk);
    check("late_ack_done", 32'(o_done), 32'd0);
    @(posedge clk); #2;
    i_mem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_state", 32'(o_current_state), 32'(MEM_IDLE));
    check("late_ack_req", 32'(o_mem_req), 32'd0);
    check("queue_empty", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
